// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the bus mux slice: transfer types,
// response codes, decode prefix width and default-slave state encoding.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int PREFIX_W = 8;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_ERR1 = 2'd1;
    localparam logic [1:0] D_ERR2 = 2'd2;

    typedef enum logic [2:0] {
        DSEL_S0,
        DSEL_S1,
        DSEL_S2,
        DSEL_S3,
        DSEL_D
    } dsel_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses. With AHB_MUX_DEFAULT_ERR_EN it
// answers valid transfers with the two-cycle ERROR and records the
// offending address (err_addr_o); otherwise it is a zero-wait OKAY slave.
// Ports: HCLK/HRESETn, haddr_i/htrans_i (address phase), sel_i (decode
// hit), hready_i (bus ready), hreadyout_o/hresp_o/hrdata_o (response).
module ahb_default_slave
    import ahb_lite_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        sel_i,
    input  logic        hready_i,
    output logic        hreadyout_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o
`ifdef AHB_MUX_DEFAULT_ERR_EN
    ,
    output logic [31:0] err_addr_o
`endif
);

    assign hrdata_o = 32'h0;

`ifdef AHB_MUX_DEFAULT_ERR_EN

    logic [1:0]  state_q, state_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        start;

    // NONSEQ/SEQ only; IDLE/BUSY get a zero-wait OKAY
    assign start = hready_i && sel_i && htrans_i[1];

    always_comb begin
        state_d    = state_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            D_IDLE:  state_d = start ? D_ERR1 : D_IDLE;
            D_ERR1:  state_d = D_ERR2;
            D_ERR2:  state_d = start ? D_ERR1 : D_IDLE;
            default: state_d = D_IDLE;
        endcase
        if (start && state_q != D_ERR1) begin
            err_addr_d = haddr_i;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= D_IDLE;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign hreadyout_o = (state_q != D_ERR1);
    assign hresp_o     = (state_q == D_IDLE) ? HRESP_OKAY : HRESP_ERROR;
    assign err_addr_o  = err_addr_q;

`else

    logic unused_ok;

    // Only D_IDLE exists: the inputs have no effect on the response
    assign unused_ok = ^{HCLK, HRESETn, haddr_i, htrans_i,
                         sel_i, hready_i};

    assign hreadyout_o = 1'b1;
    assign hresp_o     = HRESP_OKAY;

`endif

endmodule

// File: rtl/ahb_lite_bus_mux.sv
// AHB-Lite interconnect: HADDR[31:24] decode to one-hot HSEL_S0..S3,
// data-phase select register, and HRDATA/HREADY/HRESP return mux.
// Unmapped addresses go to ahb_default_slave; ERR_ADDR exists only
// when AHB_MUX_DEFAULT_ERR_EN is defined.
module ahb_lite_bus_mux
    import ahb_lite_pkg::*;
#(
    parameter logic [PREFIX_W-1:0] S0_PREFIX = 8'h00,
    parameter logic [PREFIX_W-1:0] S1_PREFIX = 8'h50,
    parameter logic [PREFIX_W-1:0] S2_PREFIX = 8'h51,
    parameter logic [PREFIX_W-1:0] S3_PREFIX = 8'h52
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL_S0,
    output logic        HSEL_S1,
    output logic        HSEL_S2,
    output logic        HSEL_S3,
    input  logic [31:0] HRDATA_S0,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic [31:0] HRDATA_S3,
    input  logic        HREADYOUT_S0,
    input  logic        HREADYOUT_S1,
    input  logic        HREADYOUT_S2,
    input  logic        HREADYOUT_S3,
    input  logic        HRESP_S0,
    input  logic        HRESP_S1,
    input  logic        HRESP_S2,
    input  logic        HRESP_S3,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
`ifdef AHB_MUX_DEFAULT_ERR_EN
    ,
    output logic [31:0] ERR_ADDR
`endif
);

    dsel_e               dec_sel;
    dsel_e               dsel_q, dsel_d;
    logic [PREFIX_W-1:0] pfx;
    logic                d_hready;
    logic                d_hresp;
    logic [31:0]         d_hrdata;

    assign pfx = HADDR[31:32-PREFIX_W];

    always_comb begin
        dec_sel = DSEL_D;
        unique case (1'b1)
            pfx == S0_PREFIX: dec_sel = DSEL_S0;
            pfx == S1_PREFIX: dec_sel = DSEL_S1;
            pfx == S2_PREFIX: dec_sel = DSEL_S2;
            pfx == S3_PREFIX: dec_sel = DSEL_S3;
            default:          dec_sel = DSEL_D;
        endcase
    end

    assign HSEL_S0 = (dec_sel == DSEL_S0);
    assign HSEL_S1 = (dec_sel == DSEL_S1);
    assign HSEL_S2 = (dec_sel == DSEL_S2);
    assign HSEL_S3 = (dec_sel == DSEL_S3);

    // Address phase is only taken when the current data phase completes
    assign dsel_d = HREADY ? dec_sel : dsel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q <= DSEL_D;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    always_comb begin
        HRDATA = d_hrdata;
        HREADY = d_hready;
        HRESP  = d_hresp;
        unique case (dsel_q)
            DSEL_S0: begin
                HRDATA = HRDATA_S0;
                HREADY = HREADYOUT_S0;
                HRESP  = HRESP_S0;
            end
            DSEL_S1: begin
                HRDATA = HRDATA_S1;
                HREADY = HREADYOUT_S1;
                HRESP  = HRESP_S1;
            end
            DSEL_S2: begin
                HRDATA = HRDATA_S2;
                HREADY = HREADYOUT_S2;
                HRESP  = HRESP_S2;
            end
            DSEL_S3: begin
                HRDATA = HRDATA_S3;
                HREADY = HREADYOUT_S3;
                HRESP  = HRESP_S3;
            end
            default: begin
                HRDATA = d_hrdata;
                HREADY = d_hready;
                HRESP  = d_hresp;
            end
        endcase
    end

    ahb_default_slave u_dflt (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .haddr_i     (HADDR),
        .htrans_i    (HTRANS),
        .sel_i       (dec_sel == DSEL_D),
        .hready_i    (HREADY),
        .hreadyout_o (d_hready),
        .hresp_o     (d_hresp),
        .hrdata_o    (d_hrdata)
`ifdef AHB_MUX_DEFAULT_ERR_EN
        ,
        .err_addr_o  (ERR_ADDR)
`endif
    );

endmodule

// File: tb/tb_ahb_lite_bus_mux.sv
// Scoreboard bench for ahb_lite_bus_mux with simple register slaves.
// Follows AHB_MUX_DEFAULT_ERR_EN for the default-slave expectations.
`timescale 1ns/1ps
module tb_ahb_lite_bus_mux;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
    logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
    logic        HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
`ifdef AHB_MUX_DEFAULT_ERR_EN
    logic [31:0] ERR_ADDR;
`endif

    always #5 HCLK = ~HCLK;

    ahb_lite_bus_mux dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HSEL_S0      (HSEL_S0),
        .HSEL_S1      (HSEL_S1),
        .HSEL_S2      (HSEL_S2),
        .HSEL_S3      (HSEL_S3),
        .HRDATA_S0    (HRDATA_S0),
        .HRDATA_S1    (HRDATA_S1),
        .HRDATA_S2    (HRDATA_S2),
        .HRDATA_S3    (HRDATA_S3),
        .HREADYOUT_S0 (HREADYOUT_S0),
        .HREADYOUT_S1 (HREADYOUT_S1),
        .HREADYOUT_S2 (HREADYOUT_S2),
        .HREADYOUT_S3 (HREADYOUT_S3),
        .HRESP_S0     (HRESP_S0),
        .HRESP_S1     (HRESP_S1),
        .HRESP_S2     (HRESP_S2),
        .HRESP_S3     (HRESP_S3),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP)
`ifdef AHB_MUX_DEFAULT_ERR_EN
        ,
        .ERR_ADDR     (ERR_ADDR)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Slave models: one register each, programmable wait states
    logic [31:0] mem [4];
    int          wcfg [4];
    int          wcnt [4];
    logic        wpend [4];
    logic [3:0]  hsel;
    logic [31:0] exp_mem [4];

    assign hsel = {HSEL_S3, HSEL_S2, HSEL_S1, HSEL_S0};
    assign HRDATA_S0 = mem[0];
    assign HRDATA_S1 = mem[1];
    assign HRDATA_S2 = mem[2];
    assign HRDATA_S3 = mem[3];
    assign HREADYOUT_S0 = (wcnt[0] == 0);
    assign HREADYOUT_S1 = (wcnt[1] == 0);
    assign HREADYOUT_S2 = (wcnt[2] == 0);
    assign HREADYOUT_S3 = (wcnt[3] == 0);
    assign HRESP_S0 = 1'b0;
    assign HRESP_S1 = 1'b0;
    assign HRESP_S2 = 1'b0;
    assign HRESP_S3 = 1'b0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 4; i++) begin
                mem[i]   <= 32'hC0DE_0000 | i;
                wcnt[i]  <= 0;
                wpend[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (HREADY && wpend[i]) mem[i] <= HWDATA;
                if (HREADY) begin
                    wpend[i] <= hsel[i] && HTRANS[1] && HWRITE;
                    wcnt[i]  <= (hsel[i] && HTRANS[1]) ? wcfg[i] : 0;
                end else if (wcnt[i] != 0) begin
                    wcnt[i] <= wcnt[i] - 1;
                end
            end
        end
    end

    typedef struct {
        logic        chk_d;
        logic [31:0] data;
        logic        resp;
        int          waits;
        logic        err;
        logic [31:0] addr;
    } item_t;

    item_t       q[$];
    logic        act = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] pend_wd = 32'h0;

    function automatic int slot(input logic [31:0] a);
        logic [7:0] p;
        p = a[31:24];
        case (p)
            8'h00:   return 0;
            8'h50:   return 1;
            8'h51:   return 2;
            8'h52:   return 3;
            default: return 4;
        endcase
    endfunction

    // Drive one address phase and hold it until it is accepted
    task automatic drive(input logic [31:0] a, input logic [1:0] t,
                         input logic w, input logic [31:0] wd);
        item_t      it;
        int         s;
        int         b;
        logic [3:0] eh;
        s = slot(a);
        HADDR  = a;
        HTRANS = t;
        HWRITE = w;
        HWDATA = pend_wd;
        pend_wd = w ? wd : 32'h0;
        act = 1'b1;
        it.chk_d = 1'b0;
        it.data  = 32'h0;
        it.resp  = HRESP_OKAY;
        it.waits = 0;
        it.err   = 1'b0;
        it.addr  = a;
        if (s < 4) begin
            if (t[1]) begin
                it.waits = wcfg[s];
                if (w) exp_mem[s] = wd;
                else begin
                    it.chk_d = 1'b1;
                    it.data  = exp_mem[s];
                end
            end
        end else begin
            it.chk_d = 1'b1;
`ifdef AHB_MUX_DEFAULT_ERR_EN
            if (t[1]) begin
                it.resp  = HRESP_ERROR;
                it.waits = 1;
                it.err   = 1'b1;
            end
`endif
        end
        q.push_back(it);
        eh = 4'b0000;
        if (s < 4) eh[s] = 1'b1;
        #1;
        chk("hsel", {28'h0, hsel}, {28'h0, eh});
        @(negedge HCLK);
        b = 0;
        while (!HREADY && b < 20) begin
            b++;
            @(negedge HCLK);
        end
        if (!HREADY) chk("accept_timeout", {31'h0, HREADY}, 32'h1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle(input int n);
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HWDATA = pend_wd;
        pend_wd = 32'h0;
        act = 1'b0;
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Monitor: pop the data-phase item when HREADY completes it
    initial begin
        item_t it;
        logic  dp_valid;
        int    nw;
        dp_valid = 1'b0;
        nw = 0;
        forever begin
            @(negedge HCLK);
            if (mon_en) begin
                if (dp_valid) begin
                    if (q.size() == 0) begin
                        chk("q_underflow", 32'h0, 32'h1);
                    end else if (HREADY) begin
                        it = q.pop_front();
                        chk("resp", {31'h0, HRESP}, {31'h0, it.resp});
                        if (it.chk_d) chk("rdata", HRDATA, it.data);
                        chk("waits", nw, it.waits);
`ifdef AHB_MUX_DEFAULT_ERR_EN
                        if (it.err) chk("err_addr", ERR_ADDR, it.addr);
`endif
                        nw = 0;
                    end else begin
                        nw++;
                        chk("wait_resp", {31'h0, HRESP},
                            {31'h0, q[0].resp});
                    end
                end
                if (HREADY) dp_valid = act;
            end else begin
                dp_valid = 1'b0;
                nw = 0;
            end
        end
    end

    task automatic chk_rst(input string tag);
        chk({tag, "_hready"}, {31'h0, HREADY}, 32'h1);
        chk({tag, "_hresp"}, {31'h0, HRESP}, 32'h0);
        chk({tag, "_hrdata"}, HRDATA, 32'h0);
`ifdef AHB_MUX_DEFAULT_ERR_EN
        chk({tag, "_err_addr"}, ERR_ADDR, 32'h0);
`endif
    endtask

    initial begin
        int b;
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HWDATA = 32'h0;
        for (int i = 0; i < 4; i++) begin
            wcfg[i]    = 0;
            exp_mem[i] = 32'hC0DE_0000 | i;
        end
        #1;
        chk_rst("rst");
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk_rst("idle");
        @(posedge HCLK);
        #1;
        mon_en = 1'b1;

        drive(32'h5000_0000, HTRANS_NONSEQ, 1'b1, 32'h0000_00A5);
        drive(32'h5000_0000, HTRANS_NONSEQ, 1'b0, 32'h0);

        wcfg[0] = 2;
        drive(32'h0000_0010, HTRANS_NONSEQ, 1'b0, 32'h0);
        wcfg[0] = 0;
        drive(32'h5100_0008, HTRANS_NONSEQ, 1'b0, 32'h0);

        drive(32'h7000_0004, HTRANS_NONSEQ, 1'b0, 32'h0);
        drive(32'h7000_0008, HTRANS_SEQ, 1'b0, 32'h0);
        drive(32'h5200_0000, HTRANS_NONSEQ, 1'b0, 32'h0);

        drive(32'h7000_0000, HTRANS_IDLE, 1'b0, 32'h0);
        drive(32'h7000_0000, HTRANS_BUSY, 1'b0, 32'h0);

        wcfg[3] = 2;
        drive(32'h5200_0004, HTRANS_NONSEQ, 1'b1, 32'h1234_5678);
        wcfg[3] = 0;
        drive(32'h7000_000C, HTRANS_NONSEQ, 1'b0, 32'h0);
        drive(32'h5200_0004, HTRANS_NONSEQ, 1'b0, 32'h0);
        drive(32'h0000_0000, HTRANS_NONSEQ, 1'b1, 32'hDEAD_BEEF);
        drive(32'h0000_0004, HTRANS_NONSEQ, 1'b0, 32'h0);
        bus_idle(2);

        b = 0;
        while (q.size() != 0 && b < 20) begin
            b++;
            @(posedge HCLK);
        end
        chk("drain", q.size(), 0);
        #1;

        drive(32'h5000_0000, HTRANS_NONSEQ, 1'b1, 32'h0000_0077);
        wcfg[2] = 3;
        drive(32'h5100_0000, HTRANS_NONSEQ, 1'b0, 32'h0);
        wcfg[2] = 0;
        mon_en = 1'b0;
        HADDR  = 32'h0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        act = 1'b0;
        @(negedge HCLK);
        chk("mid_wait", {31'h0, HREADY}, 32'h0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_rst("async_rst");
        q.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        chk_rst("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
